uart_autobaud_ctrl: RTL and testbench

- Configuration controller for the UART baud tick generator (125 MHz clock, 16x oversampling tick).
- When armed, it watches the raw RX line for a 0x55 ('U') sync character and measures the start-bit (low) width and bit-0 (high) width in clocks.
- It classifies both widths to one of four rate codes. If they agree, it drives the generator's 2-bit rate select and pulses a reset to the generator so the new divisor takes effect from phase zero.
- It sits between the RX pin and the baud rate generator / UART RX.

---
 rtl/uart_autobaud_ctrl_pkg.sv | 35 +++
 rtl/uart_autobaud_ctrl_if.sv | 33 +++
 rtl/uart_autobaud_ctrl_sync_edge.sv | 33 +++
 rtl/uart_autobaud_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_autobaud_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared constants and types for the UART auto-baud controller: rate codes,
// default measurement thresholds and the controller state encoding.
`timescale 1ns/1ps
package uart_autobaud_ctrl_pkg;

    localparam logic [1:0] RATE_115200 = 2'b11;
    localparam logic [1:0] RATE_57600  = 2'b10;
    localparam logic [1:0] RATE_19200  = 2'b01;
    localparam logic [1:0] RATE_9600   = 2'b00;

    // Bit widths in 125 MHz clocks; each class owns its lower bound.
    localparam int unsigned DEF_T_MIN     = 814;
    localparam int unsigned DEF_T_12      = 1628;
    localparam int unsigned DEF_T_23      = 4340;
    localparam int unsigned DEF_T_34      = 9766;
    localparam int unsigned DEF_T_MAX     = 16276;
    localparam int unsigned DEF_IDLE_CLKS = 16384;
    localparam int unsigned DEF_CW        = 15;

    typedef enum logic [2:0] {
        StIdle,
        StWaitIdle,
        StWaitStart,
        StMeasLo,
        StMeasHi,
        StApply,
        StErr
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] rate;
    } class_t;

endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// Control/status bundle between the RX pin side and the auto-baud controller.
`timescale 1ns/1ps
interface uart_autobaud_ctrl_if;

    logic       i_rx;
    logic       i_start;
    logic [1:0] o_bd_rate;
    logic       o_baud_rst;
    logic       o_busy;
    logic       o_locked;
    logic       o_err;

    modport master (
        output i_rx,
        output i_start,
        input  o_bd_rate,
        input  o_baud_rst,
        input  o_busy,
        input  o_locked,
        input  o_err
    );

    modport slave (
        input  i_rx,
        input  i_start,
        output o_bd_rate,
        output o_baud_rst,
        output o_busy,
        output o_locked,
        output o_err
    );

endinterface

// File: rtl/uart_autobaud_ctrl_sync_edge.sv
// Two-flop synchroniser (resets to line-idle high) with rise/fall pulses on
// the synchronised level.
`timescale 1ns/1ps
module uart_autobaud_ctrl_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: after an idle line, measures the start bit and bit 0
// of a 0x55 sync character and, if both classify alike, updates the rate.
`timescale 1ns/1ps
module uart_autobaud_ctrl
    import uart_autobaud_ctrl_pkg::*;
#(
    parameter logic [1:0]  DEFAULT_RATE = RATE_115200,
    parameter int unsigned T_MIN        = DEF_T_MIN,
    parameter int unsigned T_12         = DEF_T_12,
    parameter int unsigned T_23         = DEF_T_23,
    parameter int unsigned T_34         = DEF_T_34,
    parameter int unsigned T_MAX        = DEF_T_MAX,
    parameter int unsigned IDLE_CLKS    = DEF_IDLE_CLKS,
    parameter int unsigned CW           = DEF_CW
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    uart_autobaud_ctrl_if.slave io_bus
);

    localparam logic [CW-1:0] L_T_MIN = CW'(T_MIN);
    localparam logic [CW-1:0] L_T_12  = CW'(T_12);
    localparam logic [CW-1:0] L_T_23  = CW'(T_23);
    localparam logic [CW-1:0] L_T_34  = CW'(T_34);
    localparam logic [CW-1:0] L_T_MAX = CW'(T_MAX);
    localparam logic [CW-1:0] L_IDLE  = CW'(IDLE_CLKS);
    localparam logic [CW-1:0] L_ONE   = CW'(1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_class_lo;
    logic [1:0]    r_bd_rate;
    logic          r_baud_rst;
    logic          r_busy;
    logic          r_locked;
    logic          r_err;

    logic          w_rx_s;
    logic          w_rise;
    logic          w_fall;
    logic [CW-1:0] w_cnt_inc;
    class_t        w_cls;

    function automatic class_t classify(input logic [CW-1:0] w);
        class_t c;
        c.valid = (w >= L_T_MIN) && (w <= L_T_MAX);
        if (w < L_T_12) begin
            c.rate = RATE_115200;
        end else if (w < L_T_23) begin
            c.rate = RATE_57600;
        end else if (w < L_T_34) begin
            c.rate = RATE_19200;
        end else begin
            c.rate = RATE_9600;
        end
        return c;
    endfunction

    uart_autobaud_ctrl_sync_edge u_sync_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (io_bus.i_rx),
        .o_level (w_rx_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Saturating so a stuck line can never wrap back into a valid width.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + L_ONE;
    assign w_cls     = classify(r_cnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_class_lo <= '0;
            r_bd_rate  <= DEFAULT_RATE;
            r_baud_rst <= 1'b0;
            r_busy     <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_baud_rst <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.i_start) begin
                        r_err    <= 1'b0;
                        r_locked <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    if (!w_rx_s) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == L_IDLE) begin
                            r_state <= StWaitStart;
                        end
                    end
                end
                StWaitStart: begin
                    if (w_fall) begin
                        r_cnt   <= L_ONE;
                        r_state <= StMeasLo;
                    end
                end
                StMeasLo: begin
                    if (w_rise) begin
                        if (r_cnt < L_T_MIN) begin
                            r_state <= StWaitStart;
                        end else if (!w_cls.valid) begin
                            r_err   <= 1'b1;
                            r_state <= StErr;
                        end else begin
                            r_class_lo <= w_cls.rate;
                            r_cnt      <= L_ONE;
                            r_state    <= StMeasHi;
                        end
                    end else if (r_cnt > L_T_MAX) begin
                        r_err   <= 1'b1;
                        r_state <= StErr;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StMeasHi: begin
                    if (w_fall) begin
                        if (w_cls.valid && (w_cls.rate == r_class_lo)) begin
                            // Rate and generator reset land on the same edge.
                            r_bd_rate  <= r_class_lo;
                            r_baud_rst <= 1'b1;
                            r_locked   <= 1'b1;
                            r_state    <= StApply;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StErr;
                        end
                    end else if (r_cnt > L_T_MAX) begin
                        r_err   <= 1'b1;
                        r_state <= StErr;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StApply: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                StErr: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.o_bd_rate  = r_bd_rate;
    assign io_bus.o_baud_rst = r_baud_rst;
    assign io_bus.o_busy     = r_busy;
    assign io_bus.o_locked   = r_locked;
    assign io_bus.o_err      = r_err;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: a table of sync-character widths plus
// hand-written glitch, idle-restart, break and mid-measurement reset cases.
`timescale 1ns/1ps
module tb_uart_autobaud_ctrl;
    import uart_autobaud_ctrl_pkg::*;

    // Shortened idle qualification keeps the run short; thresholds stay real.
    localparam int IDLE_TB = 256;

    typedef struct packed {
        int         lo;
        int         hi;
        logic [1:0] rate;
        logic       locked;
        logic       err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    uart_autobaud_ctrl_if bus ();

    uart_autobaud_ctrl #(
        .IDLE_CLKS (IDLE_TB)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_brst = 0;
    int brst_cyc = 0;
    int busy_fall_cyc = 0;
    logic [1:0] brst_rate = 2'b00;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_baud_rst) begin
            n_brst    = n_brst + 1;
            brst_cyc  = cyc;
            brst_rate = bus.o_bd_rate;
        end
        if (prev_busy && !bus.o_busy) busy_fall_cyc = cyc;
        prev_busy = bus.o_busy;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        bus.i_rx = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    // Arm, qualify idle, send start bit and bit 0, then the bit-1 fall.
    task automatic run_frame(input int lo, input int hi, output int c0);
        pulse_start();
        hold(1'b1, IDLE_TB + 8);
        hold(1'b0, lo);
        hold(1'b1, hi);
        c0 = cyc;
        hold(1'b0, 8);
        hold(1'b1, 4);
    endtask

    task automatic check_result(input string tag, input int b0, input int c0,
                                input logic [1:0] rate, input logic locked,
                                input logic err);
        check({tag, " rate"}, int'(bus.o_bd_rate), int'(rate));
        check({tag, " locked"}, int'(bus.o_locked), int'(locked));
        check({tag, " err"}, int'(bus.o_err), int'(err));
        check({tag, " busy"}, int'(bus.o_busy), 0);
        check({tag, " baud_rst pulses"}, n_brst - b0, locked ? 1 : 0);
        if (locked) begin
            check({tag, " apply latency"}, brst_cyc - c0, 3);
            check({tag, " rate at baud_rst"}, int'(brst_rate), int'(rate));
            check({tag, " busy fall"}, busy_fall_cyc - brst_cyc, 1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " rate"}, int'(bus.o_bd_rate), 3);
        check({tag, " baud_rst"}, int'(bus.o_baud_rst), 0);
        check({tag, " busy"}, int'(bus.o_busy), 0);
        check({tag, " locked"}, int'(bus.o_locked), 0);
        check({tag, " err"}, int'(bus.o_err), 0);
    endtask

    vec_t vecs [6];

    initial begin
        int b0;
        int c0;

        vecs[0] = '{lo: 1085,  hi: 1085,  rate: 2'b11, locked: 1'b1, err: 1'b0};
        vecs[1] = '{lo: 13021, hi: 13021, rate: 2'b00, locked: 1'b1, err: 1'b0};
        vecs[2] = '{lo: 6510,  hi: 6510,  rate: 2'b01, locked: 1'b1, err: 1'b0};
        vecs[3] = '{lo: 1627,  hi: 1627,  rate: 2'b11, locked: 1'b1, err: 1'b0};
        vecs[4] = '{lo: 1628,  hi: 1628,  rate: 2'b10, locked: 1'b1, err: 1'b0};
        vecs[5] = '{lo: 1085,  hi: 2170,  rate: 2'b10, locked: 1'b0, err: 1'b1};

        bus.i_rx    = 1'b1;
        bus.i_start = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        hold(1'b1, 4);

        // Glitch shorter than T_MIN is dropped, the following frame locks.
        b0 = n_brst;
        pulse_start();
        hold(1'b1, IDLE_TB + 8);
        hold(1'b0, 500);
        hold(1'b1, 300);
        check("glitch err", int'(bus.o_err), 0);
        check("glitch busy", int'(bus.o_busy), 1);
        hold(1'b0, 2170);
        hold(1'b1, 2170);
        c0 = cyc;
        hold(1'b0, 8);
        hold(1'b1, 4);
        check_result("glitch", b0, c0, 2'b10, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            b0 = n_brst;
            run_frame(vecs[i].lo, vecs[i].hi, c0);
            check_result($sformatf("vec%0d", i), b0, c0, vecs[i].rate, vecs[i].locked,
                         vecs[i].err);
        end

        // Low during idle qualification restarts it; start while busy is ignored.
        b0 = n_brst;
        pulse_start();
        check("rearm err cleared", int'(bus.o_err), 0);
        check("rearm busy", int'(bus.o_busy), 1);
        hold(1'b1, 200);
        hold(1'b0, 10);
        hold(1'b1, 200);
        hold(1'b0, 1085);
        hold(1'b1, 1085);
        hold(1'b0, 400);
        check("restart locked", int'(bus.o_locked), 0);
        check("restart busy", int'(bus.o_busy), 1);
        bus.i_start = 1'b1;
        hold(1'b0, 1);
        bus.i_start = 1'b0;
        hold(1'b0, 1769);
        hold(1'b1, 2170);
        c0 = cyc;
        hold(1'b0, 8);
        hold(1'b1, 4);
        check_result("restart", b0, c0, 2'b10, 1'b1, 1'b0);

        // Break: low beyond T_MAX raises err without waiting for a rise.
        b0 = n_brst;
        pulse_start();
        hold(1'b1, IDLE_TB + 8);
        hold(1'b0, 16270);
        check("break early err", int'(bus.o_err), 0);
        check("break early busy", int'(bus.o_busy), 1);
        hold(1'b0, 20);
        check("break err", int'(bus.o_err), 1);
        check("break busy", int'(bus.o_busy), 0);
        check("break locked", int'(bus.o_locked), 0);
        check("break rate", int'(bus.o_bd_rate), 2);
        check("break baud_rst pulses", n_brst - b0, 0);
        hold(1'b1, 8);

        // Asynchronous reset in the middle of bit 0.
        b0 = n_brst;
        pulse_start();
        hold(1'b1, IDLE_TB + 8);
        hold(1'b0, 1085);
        hold(1'b1, 500);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 4);
        check("async reset baud_rst pulses", n_brst - b0, 0);

        b0 = n_brst;
        run_frame(2170, 2170, c0);
        check_result("fresh", b0, c0, 2'b10, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
